// File: rtl/acc_pkg.sv
// Shared sizes, memory-port payloads and FSM states for the search-window fetch block.
// SMEM_LOAD_EN adds the LOAD state used by the optional image loader.
package acc_pkg;

  localparam int unsigned BlkDim = 16;
  localparam int unsigned ImgDim = 31;
  localparam int unsigned AddrW  = 10;
  localparam int unsigned PixW   = 8;
  localparam int unsigned CntW   = 4;

  typedef struct packed {
    logic                         write;
    logic [AddrW-1:0]             waddr;
    logic [PixW-1:0]              wdata;
    logic [BlkDim-1:0][AddrW-1:0] raddr;
  } smem_req_t;

  typedef struct packed {
    logic [BlkDim-1:0][PixW-1:0] data;
  } smem_res_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
`ifdef SMEM_LOAD_EN
    ST_LOAD,
`endif
    ST_DONE
  } fetch_state_t;

endpackage

// File: rtl/win_addr_gen.sv
// Sweep counters (r innermost, then cx, then cy) and per-lane read addresses
// for one BlkDim-wide row of the candidate block.
module win_addr_gen
  import acc_pkg::*;
#(
  parameter int unsigned BlkDim = acc_pkg::BlkDim,
  parameter int unsigned ImgDim = acc_pkg::ImgDim
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv,
  output logic [CntW-1:0]              cx,
  output logic [CntW-1:0]              cy,
  output logic [CntW-1:0]              r,
  output logic                         last_c,
  output logic [BlkDim-1:0][AddrW-1:0] raddr_c
);

  localparam logic [CntW-1:0] RMax = CntW'(BlkDim - 1);
  localparam logic [CntW-1:0] CMax = CntW'(ImgDim - BlkDim);

  logic [AddrW-1:0] row_base;

  // Counters wrap back to zero after the final beat, ready for the next sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
      r  <= '0;
    end else if (adv) begin
      if (r == RMax) begin
        r <= '0;
        if (cx == CMax) begin
          cx <= '0;
          cy <= (cy == CMax) ? '0 : cy + CntW'(1);
        end else begin
          cx <= cx + CntW'(1);
        end
      end else begin
        r <= r + CntW'(1);
      end
    end
  end

  assign last_c   = (r == RMax) && (cx == CMax) && (cy == CMax);
  assign row_base = (AddrW'(cy) + AddrW'(r)) * AddrW'(ImgDim);

  for (genvar i = 0; i < BlkDim; i++) begin : g_lane
    assign raddr_c[i] = row_base + AddrW'(cx) + AddrW'(i);
  end

endmodule

// File: rtl/search_win_fetch.sv
// Streams every candidate block row of the search image as BlkDim-pixel beats.
// Define SMEM_LOAD_EN to add a byte-serial loader that fills the search memory.
module search_win_fetch
  import acc_pkg::*;
#(
  parameter int unsigned BlkDim = acc_pkg::BlkDim,
  parameter int unsigned ImgDim = acc_pkg::ImgDim
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output smem_req_t                   mem_req_o,
  input  smem_res_t                   mem_res_i,
  output logic                        row_valid_o,
  input  logic                        row_ready_i,
  output logic [BlkDim-1:0][PixW-1:0] row_data_o,
  output logic [CntW-1:0]             row_cx_o,
  output logic [CntW-1:0]             row_cy_o,
  output logic [CntW-1:0]             row_r_o,
  output logic                        row_last_o
`ifdef SMEM_LOAD_EN
  ,
  input  logic                        load_i,
  input  logic                        ld_valid_i,
  output logic                        ld_ready_o,
  input  logic [PixW-1:0]             ld_data_i
`endif
);

  fetch_state_t                 state_q, state_d;
  logic                         capture, accept;
  logic [CntW-1:0]              cx, cy, r;
  logic                         last_c;
  logic [BlkDim-1:0][AddrW-1:0] raddr_c;

`ifdef SMEM_LOAD_EN
  localparam int unsigned LoadBytes = ImgDim * ImgDim;
  logic [AddrW-1:0] ld_cnt_q;
  logic             ld_fire;
`endif

  win_addr_gen #(
    .BlkDim (BlkDim),
    .ImgDim (ImgDim)
  ) u_addr (
    .clk     (clk_i),
    .rst     (rst_i),
    .adv     (capture),
    .cx      (cx),
    .cy      (cy),
    .r       (r),
    .last_c  (last_c),
    .raddr_c (raddr_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a beat is captured whenever the output register is free or draining.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = row_valid_o && row_ready_i;
`ifdef SMEM_LOAD_EN
    ld_fire = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
`ifdef SMEM_LOAD_EN
        else if (load_i) state_d = ST_LOAD;
`endif
      end
      ST_FETCH: begin
        capture = !row_valid_o || row_ready_i;
        if (capture && last_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept) state_d = ST_DONE;
      end
`ifdef SMEM_LOAD_EN
      ST_LOAD: begin
        ld_fire = ld_valid_i;
        if (ld_fire && (ld_cnt_q == AddrW'(LoadBytes - 1))) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read addresses only while fetching; the write port only on a loader handshake.
  always_comb begin
    mem_req_o = '0;
    if (state_q == ST_FETCH) mem_req_o.raddr = raddr_c;
`ifdef SMEM_LOAD_EN
    if (ld_fire) begin
      mem_req_o.write = 1'b1;
      mem_req_o.waddr = ld_cnt_q;
      mem_req_o.wdata = ld_data_i;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      row_valid_o <= 1'b0;
      row_data_o  <= '0;
      row_cx_o    <= '0;
      row_cy_o    <= '0;
      row_r_o     <= '0;
      row_last_o  <= 1'b0;
    end else begin
      busy_o <= (state_d != ST_IDLE);
      done_o <= (state_d == ST_DONE);
      if (capture) begin
        row_valid_o <= 1'b1;
        row_data_o  <= mem_res_i.data;
        row_cx_o    <= cx;
        row_cy_o    <= cy;
        row_r_o     <= r;
        row_last_o  <= last_c;
      end else if (accept) begin
        row_valid_o <= 1'b0;
        row_last_o  <= 1'b0;
      end
    end
  end

`ifdef SMEM_LOAD_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_cnt_q   <= '0;
      ld_ready_o <= 1'b0;
    end else begin
      ld_ready_o <= (state_d == ST_LOAD);
      if (ld_fire) ld_cnt_q <= (ld_cnt_q == AddrW'(LoadBytes - 1)) ? '0 : ld_cnt_q + AddrW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_search_win_fetch.sv
// Directed bench for search_win_fetch: ramp image, beat-order scoreboard, stalls, reset abort.
module tb_search_win_fetch;
  import acc_pkg::*;

  localparam int NBeats = 4096;
  localparam int MaxC   = int'(ImgDim) - int'(BlkDim);

  typedef struct packed {
    logic [3:0]                  cx;
    logic [3:0]                  cy;
    logic [3:0]                  r;
    logic                        last;
    logic [BlkDim-1:0][PixW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst, start, busy, done, row_valid, row_ready, row_last;
  smem_req_t mem_req;
  smem_res_t mem_res;
  logic [BlkDim-1:0][PixW-1:0] row_data;
  logic [CntW-1:0] row_cx, row_cy, row_r;
`ifdef SMEM_LOAD_EN
  logic load, ld_valid, ld_ready;
  logic [7:0] ld_data;
  bit ld_mon = 1'b0;
  int wr_cnt, ld_done;
`endif

  logic [7:0] img [0:1023];
  beat_t exp_q [$];
  beat_t cur_b, exp_b, held_b;
  int total = 0, bad = 0;
  bit chk_en = 1'b0, hold_pend = 1'b0;
  int cyc, beats, done_cnt, done_cyc, first_cyc, last_acc_cyc;

  always #5 clk = ~clk;

  search_win_fetch dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .mem_req_o   (mem_req),
    .mem_res_i   (mem_res),
    .row_valid_o (row_valid),
    .row_ready_i (row_ready),
    .row_data_o  (row_data),
    .row_cx_o    (row_cx),
    .row_cy_o    (row_cy),
    .row_r_o     (row_r),
    .row_last_o  (row_last)
`ifdef SMEM_LOAD_EN
    ,
    .load_i      (load),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_data_i   (ld_data)
`endif
  );

  // Combinational search memory
  always_comb begin
    for (int i = 0; i < BlkDim; i++) mem_res.data[i] = img[mem_req.raddr[i]];
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // Expected beat stream straight from the sweep-order rule and the image contents
  task automatic build_expected();
    beat_t b;
    exp_q.delete();
    for (int cy = 0; cy <= MaxC; cy++)
      for (int cx = 0; cx <= MaxC; cx++)
        for (int r = 0; r < int'(BlkDim); r++) begin
          b.cx   = 4'(cx);
          b.cy   = 4'(cy);
          b.r    = 4'(r);
          b.last = (cx == MaxC) && (cy == MaxC) && (r == int'(BlkDim) - 1);
          for (int i = 0; i < int'(BlkDim); i++) b.data[i] = img[(cy + r) * int'(ImgDim) + cx + i];
          exp_q.push_back(b);
        end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cur_b.cx   = row_cx;
      cur_b.cy   = row_cy;
      cur_b.r    = row_r;
      cur_b.last = row_last;
      cur_b.data = row_data;
      cyc++;
      if (hold_pend) chk("hold", 256'({row_valid, cur_b}), 256'({1'b1, held_b}));
      hold_pend = row_valid && !row_ready;
      held_b    = cur_b;
      if (row_valid && row_ready) begin
        chk("write_idle", 256'(mem_req.write), 256'(0));
        if (exp_q.size() == 0) chk("extra_beat", 256'(beats + 1), 256'(NBeats));
        else begin
          exp_b = exp_q.pop_front();
          chk("beat", 256'(cur_b), 256'(exp_b));
        end
        if (row_cx == 4'd0 && row_cy == 4'd0 && row_r == 4'd0) begin
          chk("b000_lane0", 256'(row_data[0]), 256'(0));
          chk("b000_lane15", 256'(row_data[15]), 256'(15));
        end
        if (row_cx == 4'd2 && row_cy == 4'd1 && row_r == 4'd3) begin
          chk("b213_lane0", 256'(row_data[0]), 256'(126));
          chk("b213_lane15", 256'(row_data[15]), 256'(141));
        end
        if (row_cx == 4'd15 && row_cy == 4'd15 && row_r == 4'd15) begin
          chk("bmax_lane0", 256'(row_data[0]), 256'(177));
          chk("bmax_lane15", 256'(row_data[15]), 256'(192));
          chk("bmax_last", 256'(row_last), 256'(1));
        end
        beats++;
        if (beats == 1) first_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
`ifdef SMEM_LOAD_EN
    if (ld_mon) begin
      if (mem_req.write) begin
        chk("ld_addr", 256'(mem_req.waddr), 256'(wr_cnt));
        chk("ld_data", 256'(mem_req.wdata), 256'(8'hA5));
        chk("ld_handshake", 256'(ld_valid && ld_ready), 256'(1));
        wr_cnt++;
      end
      if (done) ld_done++;
    end
`endif
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_valid"}, 256'(row_valid), 256'(0));
    chk({tag, "_data"}, 256'(row_data), 256'(0));
    chk({tag, "_cnt"}, 256'({row_cx, row_cy, row_r, row_last}), 256'(0));
    chk({tag, "_memreq"}, 256'(mem_req), 256'(0));
  endtask

  task automatic run_sweep(input bit rnd, input int abort_at);
    int guard;
    build_expected();
    beats = 0; done_cnt = 0; cyc = 0; first_cyc = 0; last_acc_cyc = 0; done_cyc = 0;
    hold_pend = 1'b0;
    row_ready = 1'b1;
    chk_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat_busy", 256'(busy), 256'(1));
    chk("lat_valid0", 256'(row_valid), 256'(0));
    @(negedge clk);
    chk("lat_valid1", 256'(row_valid), 256'(1));
    guard = 0;
    while (guard < 40000 && done_cnt == 0 && !(abort_at >= 0 && beats >= abort_at)) begin
      @(posedge clk); #1;
      guard++;
      if (rnd) row_ready = 1'($urandom_range(0, 1));
    end
    chk("timeout", 256'(guard < 40000), 256'(1));
    if (abort_at >= 0) begin
      chk_en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero("abort");
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", 256'({done, busy}), 256'(0));
      end
    end else begin
      row_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      chk("beat_count", 256'(beats), 256'(NBeats));
      chk("queue_empty", 256'(exp_q.size()), 256'(0));
      chk("done_once", 256'(done_cnt), 256'(1));
      chk("done_timing", 256'(done_cyc), 256'(last_acc_cyc + 1));
      chk("idle_after", 256'(busy), 256'(0));
      if (!rnd) chk("no_bubble", 256'(last_acc_cyc - first_cyc), 256'(NBeats - 1));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_ready = 1'b1;
`ifdef SMEM_LOAD_EN
    load = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
`endif
    for (int a = 0; a < 1024; a++) img[a] = 8'(a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");

    // start coinciding with reset must be ignored
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 256'(busy), 256'(0));
    @(negedge clk);
    chk("rst_start_valid", 256'({busy, row_valid}), 256'(0));

    run_sweep(1'b0, -1);
    run_sweep(1'b1, -1);
    run_sweep(1'b0, 100);
    run_sweep(1'b0, -1);

`ifdef SMEM_LOAD_EN
    begin
      int sent, g;
      sent = 0; g = 0; wr_cnt = 0; ld_done = 0;
      @(posedge clk); #1;
      load = 1'b1;
      ld_data = 8'hA5;
      ld_mon = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      while (sent < 961 && g < 20000) begin
        ld_valid = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (ld_valid && ld_ready) sent++;
        @(posedge clk); #1;
        g++;
      end
      ld_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      ld_mon = 1'b0;
      chk("ld_writes", 256'(wr_cnt), 256'(961));
      chk("ld_done", 256'(ld_done), 256'(1));
      chk("ld_idle", 256'(busy), 256'(0));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
